// File: rtl/spi_tx_arbiter_if.sv
// Bundle between the frame sources/serializer and spi_tx_arbiter.
// The arbiter connects through the slave modport; the environment drives through master.
interface spi_tx_arbiter_if #(
  parameter int unsigned N_REQ  = 3,
  parameter int unsigned WORD_W = 16,
  parameter int unsigned LEN_W  = 4,
  parameter int unsigned ADDR_W = 3
);
  logic [N_REQ-1:0]        REQ;
  logic [N_REQ*LEN_W-1:0]  LEN;
  logic [N_REQ*ADDR_W-1:0] ADDR_IN;
  logic [N_REQ*WORD_W-1:0] WORD_IN;
  logic [LEN_W-1:0]        WORD_IDX;
  logic [N_REQ-1:0]        GRANT;
  logic [N_REQ-1:0]        DONE;
  logic [WORD_W-1:0]       SER_DATA;
  logic [ADDR_W-1:0]       SER_ADDR;
  logic                    SER_ENA;
  logic                    SER_BUSY;

  modport master (
    output REQ, LEN, ADDR_IN, WORD_IN, SER_BUSY,
    input  WORD_IDX, GRANT, DONE, SER_DATA, SER_ADDR, SER_ENA
  );

  modport slave (
    input  REQ, LEN, ADDR_IN, WORD_IN, SER_BUSY,
    output WORD_IDX, GRANT, DONE, SER_DATA, SER_ADDR, SER_ENA
  );
endinterface

// File: rtl/spi_tx_arbiter.sv
// Shares one ENA/BUSY serializer between N_REQ frame sources, one frame at a time.
// Define SPI_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority.
module spi_tx_arbiter #(
  parameter int unsigned N_REQ  = 3,
  parameter int unsigned WORD_W = 16,
  parameter int unsigned LEN_W  = 4,
  parameter int unsigned ADDR_W = 3
) (
  input logic             RX_CLK,
  input logic             RST,
  spi_tx_arbiter_if.slave bus
);
  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic [N_REQ-1:0]    done_q, done_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    word_idx_q, word_idx_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   ser_addr_q, ser_addr_d;
  logic [WORD_W-1:0]   ser_data_q, ser_data_d;
  logic                ser_ena_q, ser_ena_d;
  logic [IDX_W-1:0]    winner_c;

`ifdef SPI_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0]    ptr_q, ptr_d;

  // Search starts one past the last winner, wrapping modulo N_REQ.
  always_comb begin
    logic        found;
    int unsigned cand;
    winner_c = '0;
    found    = 1'b0;
    cand     = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!found && bus.REQ[IDX_W'(cand)]) begin
        winner_c = IDX_W'(cand);
        found    = 1'b1;
      end
    end
  end
`else
  // Fixed priority: lowest requesting index wins.
  always_comb begin
    winner_c = '0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (bus.REQ[IDX_W'(i)]) winner_c = IDX_W'(i);
    end
  end
`endif

  // Frame sequencing and serializer handshake.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    done_d     = '0;
    owner_d    = owner_q;
    len_d      = len_q;
    addr_d     = addr_q;
    word_idx_d = word_idx_q;
    ser_data_d = ser_data_q;
    ser_addr_d = ser_addr_q;
    ser_ena_d  = 1'b0;
`ifdef SPI_ARB_ROUND_ROBIN_EN
    ptr_d      = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (|bus.REQ) begin
          owner_d    = winner_c;
          grant_d    = N_REQ'(1) << winner_c;
          len_d      = bus.LEN[winner_c*LEN_W +: LEN_W];
          addr_d     = bus.ADDR_IN[winner_c*ADDR_W +: ADDR_W];
          word_idx_d = '0;
          state_d    = LOAD;
`ifdef SPI_ARB_ROUND_ROBIN_EN
          ptr_d      = winner_c;
`endif
        end
      end
      LOAD: begin
        if (len_q == '0) begin
          done_d  = grant_q;
          grant_d = '0;
          state_d = IDLE;
        end else begin
          ser_data_d = bus.WORD_IN[owner_q*WORD_W +: WORD_W];
          ser_addr_d = addr_q;
          ser_ena_d  = 1'b1;
          state_d    = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (bus.SER_BUSY) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!bus.SER_BUSY) begin
          if (word_idx_q == len_q - LEN_W'(1)) begin
            done_d     = grant_q;
            grant_d    = '0;
            word_idx_d = '0;
            state_d    = IDLE;
          end else begin
            word_idx_d = word_idx_q + LEN_W'(1);
            state_d    = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge RX_CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      done_q     <= '0;
      owner_q    <= '0;
      len_q      <= '0;
      addr_q     <= '0;
      word_idx_q <= '0;
      ser_data_q <= '0;
      ser_addr_q <= '0;
      ser_ena_q  <= 1'b0;
`ifdef SPI_ARB_ROUND_ROBIN_EN
      ptr_q      <= IDX_W'(N_REQ - 1);
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      owner_q    <= owner_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      word_idx_q <= word_idx_d;
      ser_data_q <= ser_data_d;
      ser_addr_q <= ser_addr_d;
      ser_ena_q  <= ser_ena_d;
`ifdef SPI_ARB_ROUND_ROBIN_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

  assign bus.GRANT    = grant_q;
  assign bus.DONE     = done_q;
  assign bus.WORD_IDX = word_idx_q;
  assign bus.SER_DATA = ser_data_q;
  assign bus.SER_ADDR = ser_addr_q;
  assign bus.SER_ENA  = ser_ena_q;
endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Directed + randomized bench for spi_tx_arbiter with a frame-level scoreboard
// and a serializer model whose ack delay and busy time are programmable.
module tb_spi_tx_arbiter;
  localparam int unsigned N_REQ  = 3;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned LEN_W  = 4;
  localparam int unsigned ADDR_W = 3;

  logic RX_CLK = 1'b0;
  logic RST    = 1'b0;
  always #5 RX_CLK = ~RX_CLK;

  spi_tx_arbiter_if #(.N_REQ(N_REQ), .WORD_W(WORD_W), .LEN_W(LEN_W), .ADDR_W(ADDR_W)) bus ();

  spi_tx_arbiter #(.N_REQ(N_REQ), .WORD_W(WORD_W), .LEN_W(LEN_W), .ADDR_W(ADDR_W)) dut (
    .RX_CLK(RX_CLK),
    .RST   (RST),
    .bus   (bus)
  );

  // Requester content tables
  logic [WORD_W-1:0] word_tab [N_REQ][16];
  logic [LEN_W-1:0]  len_tab  [N_REQ];
  logic [ADDR_W-1:0] addr_tab [N_REQ];
  logic [N_REQ*LEN_W-1:0]  len_bus;
  logic [N_REQ*ADDR_W-1:0] addr_bus;
  logic [N_REQ*WORD_W-1:0] word_bus;

  always_comb begin
    len_bus  = '0;
    addr_bus = '0;
    word_bus = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      len_bus[i*LEN_W +: LEN_W]    = len_tab[i];
      addr_bus[i*ADDR_W +: ADDR_W] = addr_tab[i];
      word_bus[i*WORD_W +: WORD_W] = word_tab[i][bus.WORD_IDX];
    end
  end
  assign bus.LEN     = len_bus;
  assign bus.ADDR_IN = addr_bus;
  assign bus.WORD_IN = word_bus;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge RX_CLK) cyc <= cyc + 1;

  // Serializer model
  int ack_dly  = 0;
  int busy_len = 3;
  int fall_cyc [$];
  initial begin
    bus.SER_BUSY = 1'b0;
    forever begin
      @(negedge RX_CLK);
      if (RST && bus.SER_ENA === 1'b1) begin
        repeat (ack_dly) @(negedge RX_CLK);
        bus.SER_BUSY = 1'b1;
        repeat (busy_len) @(negedge RX_CLK);
        bus.SER_BUSY = 1'b0;
        fall_cyc.push_back(cyc);
      end
    end
  end

  // Observed streams
  logic [WORD_W-1:0] ena_data  [$];
  logic [ADDR_W-1:0] ena_addr  [$];
  logic [N_REQ-1:0]  ena_grant [$];
  logic [LEN_W-1:0]  ena_idx   [$];
  int                ena_cyc   [$];
  logic [N_REQ-1:0]  done_log  [$];
  int ena_double    = 0;
  int grant_changes = 0;
  logic             ena_prev   = 1'b0;
  logic [N_REQ-1:0] grant_prev = '0;

  always @(negedge RX_CLK) begin
    if (RST) begin
      if (bus.SER_ENA === 1'b1) begin
        ena_data.push_back(bus.SER_DATA);
        ena_addr.push_back(bus.SER_ADDR);
        ena_grant.push_back(bus.GRANT);
        ena_idx.push_back(bus.WORD_IDX);
        ena_cyc.push_back(cyc);
        if (ena_prev) ena_double++;
      end
      if (bus.DONE != '0) done_log.push_back(bus.DONE);
      if (grant_prev != '0 && bus.GRANT != '0 && bus.GRANT != grant_prev) grant_changes++;
      ena_prev   = bus.SER_ENA;
      grant_prev = bus.GRANT;
    end else begin
      ena_prev   = 1'b0;
      grant_prev = '0;
    end
  end

  // Expected streams from the reference model
  logic [WORD_W-1:0] exp_data  [$];
  logic [ADDR_W-1:0] exp_addr  [$];
  logic [N_REQ-1:0]  exp_grant [$];
  logic [LEN_W-1:0]  exp_idx   [$];
  logic [N_REQ-1:0]  exp_done  [$];
  int model_ptr = int'(N_REQ) - 1;
  logic hold_req = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Requesters drop REQ in the cycle they see their DONE bit.
  task automatic step();
    @(negedge RX_CLK);
    if (!hold_req && RST) bus.REQ = bus.REQ & ~bus.DONE;
  endtask

  function automatic int pick(input logic [N_REQ-1:0] pend);
`ifdef SPI_ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= int'(N_REQ); k++) begin
      int c;
      c = (model_ptr + k) % int'(N_REQ);
      if (pend[c]) begin
        model_ptr = c;
        return c;
      end
    end
`else
    for (int c = 0; c < int'(N_REQ); c++) if (pend[c]) return c;
`endif
    return 0;
  endfunction

  task automatic expect_frame(input int w);
    logic [N_REQ-1:0] oh;
    oh    = '0;
    oh[w] = 1'b1;
    for (int k = 0; k < int'(len_tab[w]); k++) begin
      exp_data.push_back(word_tab[w][k]);
      exp_addr.push_back(addr_tab[w]);
      exp_grant.push_back(oh);
      exp_idx.push_back(LEN_W'(k));
    end
    exp_done.push_back(oh);
  endtask

  // Requests raised together, each dropped at its own DONE.
  task automatic expect_set(input logic [N_REQ-1:0] mask);
    logic [N_REQ-1:0] pend;
    pend = mask;
    while (pend != '0) begin
      int w;
      w = pick(pend);
      pend[w] = 1'b0;
      expect_frame(w);
    end
  endtask

  task automatic clear_logs();
    ena_data.delete(); ena_addr.delete(); ena_grant.delete(); ena_idx.delete();
    ena_cyc.delete(); done_log.delete(); fall_cyc.delete();
    exp_data.delete(); exp_addr.delete(); exp_grant.delete(); exp_idx.delete(); exp_done.delete();
    ena_double = 0;
    grant_changes = 0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int   n;
    logic idle;
    n = 0;
    idle = 1'b0;
    while (!idle && n < budget) begin
      step();
      n++;
      idle = (bus.REQ == '0 && bus.GRANT == '0);
    end
    check({tag, " finished"}, 32'(idle), 32'd1);
    step();
  endtask

  task automatic compare_streams(input string tag);
    int n;
    check({tag, " ena count"}, 32'(ena_data.size()), 32'(exp_data.size()));
    n = (ena_data.size() < exp_data.size()) ? ena_data.size() : exp_data.size();
    for (int i = 0; i < n; i++) begin
      check({tag, " data"},  32'(ena_data[i]),  32'(exp_data[i]));
      check({tag, " addr"},  32'(ena_addr[i]),  32'(exp_addr[i]));
      check({tag, " grant"}, 32'(ena_grant[i]), 32'(exp_grant[i]));
      check({tag, " idx"},   32'(ena_idx[i]),   32'(exp_idx[i]));
    end
    check({tag, " done count"}, 32'(done_log.size()), 32'(exp_done.size()));
    n = (done_log.size() < exp_done.size()) ? done_log.size() : exp_done.size();
    for (int i = 0; i < n; i++) check({tag, " done"}, 32'(done_log[i]), 32'(exp_done[i]));
    check({tag, " ena single cycle"}, 32'(ena_double), 32'd0);
    check({tag, " grant stable"}, 32'(grant_changes), 32'd0);
    clear_logs();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " GRANT"},    32'(bus.GRANT),    32'd0);
    check({tag, " DONE"},     32'(bus.DONE),     32'd0);
    check({tag, " SER_DATA"}, 32'(bus.SER_DATA), 32'd0);
    check({tag, " SER_ADDR"}, 32'(bus.SER_ADDR), 32'd0);
    check({tag, " SER_ENA"},  32'(bus.SER_ENA),  32'd0);
    check({tag, " WORD_IDX"}, 32'(bus.WORD_IDX), 32'd0);
  endtask

  task automatic randomize_req(input int w, input int max_len);
    len_tab[w]  = LEN_W'($urandom_range(0, max_len));
    addr_tab[w] = ADDR_W'($urandom);
    for (int k = 0; k < 16; k++) word_tab[w][k] = WORD_W'($urandom);
  endtask

  initial begin
    logic [WORD_W-1:0] single_words [6];
    int seen, n;
    single_words = '{16'h55AA, 16'h0082, 16'h0001, 16'h1000, 16'h0000, 16'h0000};
    bus.REQ = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      len_tab[i] = '0;
      addr_tab[i] = '0;
      for (int k = 0; k < 16; k++) word_tab[i][k] = '0;
    end

    // Reset state
    repeat (3) @(negedge RX_CLK);
    check_outputs_zero("reset");
    RST = 1'b1;
    step();

    // Single 6-word frame, slow serializer
    len_tab[0]  = 4'd6;
    addr_tab[0] = 3'd1;
    for (int k = 0; k < 6; k++) word_tab[0][k] = single_words[k];
    ack_dly = 1; busy_len = 17;
    expect_set(3'b001);
    bus.REQ = 3'b001;
    wait_idle("single", 1000);
    compare_streams("single");

    // Contention between requesters 1 and 2
    randomize_req(1, 0); randomize_req(2, 0);
    len_tab[1] = 4'd2; len_tab[2] = 4'd3;
    ack_dly = 0; busy_len = 3;
    expect_set(3'b110);
    bus.REQ = 3'b110;
    wait_idle("contention", 500);
    compare_streams("contention");

    // Zero-length frame
    len_tab[2] = 4'd0;
    bus.REQ = 3'b100;
    step();
    check("zero grant", 32'(bus.GRANT), 32'(3'b100));
    check("zero early done", 32'(bus.DONE), 32'd0);
    step();
    check("zero done", 32'(bus.DONE), 32'(3'b100));
    check("zero grant clear", 32'(bus.GRANT), 32'd0);
    step();
    check("zero done pulse", 32'(bus.DONE), 32'd0);
    check("zero no ena", 32'(ena_data.size()), 32'd0);
    void'(pick(3'b100));
    clear_logs();

    // Slow ack: ENA must not repeat while BUSY stays low
    randomize_req(0, 0);
    len_tab[0] = 4'd2;
    ack_dly = 10; busy_len = 5;
    expect_set(3'b001);
    bus.REQ = 3'b001;
    wait_idle("handshake", 500);
    if (ena_cyc.size() >= 2 && fall_cyc.size() >= 1) begin
      check("handshake ena after fall", 32'(ena_cyc[1] - fall_cyc[0]), 32'd2);
      check("handshake word spacing", 32'(ena_cyc[1] - ena_cyc[0]), 32'(ack_dly + busy_len + 2));
    end else begin
      check("handshake ena count", 32'(ena_cyc.size()), 32'd2);
    end
    compare_streams("handshake");

    // Reset during word 2 of 6, then restart from word 0
    randomize_req(0, 0);
    len_tab[0] = 4'd6;
    ack_dly = 0; busy_len = 8;
    bus.REQ = 3'b001;
    n = 0;
    while (!(ena_data.size() == 2 && bus.SER_BUSY === 1'b1) && n < 500) begin
      step();
      n++;
    end
    check("midreset reached word 2", 32'(ena_data.size()), 32'd2);
    RST = 1'b0;
    #1;
    check_outputs_zero("midreset");
    repeat (12) @(negedge RX_CLK);
    check("midreset no done", 32'(done_log.size()), 32'd0);
    clear_logs();
    model_ptr = int'(N_REQ) - 1;
    RST = 1'b1;
    expect_set(3'b001);
    wait_idle("restart", 1000);
    compare_streams("restart");

    // Held requests: arbitration order over five one-word frames
    RST = 1'b0;
    repeat (2) @(negedge RX_CLK);
    RST = 1'b1;
    model_ptr = int'(N_REQ) - 1;
    clear_logs();
    for (int i = 0; i < int'(N_REQ); i++) begin
      randomize_req(i, 0);
      len_tab[i] = 4'd1;
    end
    ack_dly = 0; busy_len = 2;
    for (int f = 0; f < 5; f++) expect_frame(pick(3'b111));
    hold_req = 1'b1;
    bus.REQ = 3'b111;
    seen = 0; n = 0;
    while (seen < 5 && n < 500) begin
      step();
      n++;
      if (bus.DONE != '0) seen++;
    end
    bus.REQ  = '0;
    hold_req = 1'b0;
    check("held reached five frames", 32'(seen), 32'd5);
    wait_idle("held", 100);
    compare_streams("held");

    // Randomized rounds
    for (int r = 0; r < 8; r++) begin
      logic [N_REQ-1:0] mask;
      mask = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
      for (int i = 0; i < int'(N_REQ); i++) randomize_req(i, 5);
      ack_dly  = int'($urandom_range(0, 3));
      busy_len = int'($urandom_range(1, 6));
      expect_set(mask);
      bus.REQ = mask;
      wait_idle("random", 2000);
      compare_streams("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/spi_tx_arbiter.md
Name: spi_tx_arbiter

Overview:
- Shares one serializer (16-bit word, 3-bit address, ENA/BUSY handshake) between N_REQ frame sources, e.g. board-mode, status and echo message generators.
- Grants one requester at a time and walks its frame word by word. Each word is issued to the serializer as a single-cycle ENA pulse, and the next word waits until BUSY has risen and then fallen.
- Sits between the per-message sequencers and the serializer on the RX_CLK domain.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- WORD_W, 16, serializer word width.
- LEN_W, 4, frame length field width (max 15 words).
- ADDR_W, 3, serializer address width.

Ports:
- RX_CLK  in  1  clock.
- RST  in  1  asynchronous active-low reset.
- REQ  in  N_REQ  per-requester frame request. Level; the requester holds it until it sees its DONE bit.
- LEN  in  N_REQ*LEN_W  per-requester frame length in words. Slice i = bits [i*LEN_W +: LEN_W].
- ADDR_IN  in  N_REQ*ADDR_W  per-requester serializer address.
- WORD_IN  in  N_REQ*WORD_W  per-requester word currently indexed by WORD_IDX.
- WORD_IDX  out  LEN_W  index of the word being fetched, shared by all requesters.
- GRANT  out  N_REQ  one-hot; identifies the owner of the current frame.
- DONE  out  N_REQ  one-hot, one-cycle pulse at frame end.
- SER_DATA  out  WORD_W  to serializer DATA.
- SER_ADDR  out  ADDR_W  to serializer ADDR.
- SER_ENA  out  1  to serializer ENA; one-cycle pulse per word.
- SER_BUSY  in  1  from serializer BUSY.

Behaviour:
- Reset (async, RST=0):
  - state=IDLE.
  - GRANT, DONE, SER_DATA, SER_ADDR, SER_ENA, WORD_IDX all 0.
  - Reset during a frame aborts it immediately; no DONE is issued.
- All outputs are registered.
- IDLE:
  - If REQ!=0, select a winner (see Optional Feature; default fixed priority, lowest index wins).
  - Register GRANT=onehot(winner), latch len and addr of the winner, set WORD_IDX=0, go to LOAD.
  - If the latched len==0: no ENA; DONE[winner] pulses on the next cycle, GRANT clears, return to IDLE.
- LOAD:
  - SER_DATA <= WORD_IN slice of the granted requester, SER_ADDR <= latched addr, SER_ENA <= 1.
  - Go to WAIT_ACK.
- WAIT_ACK:
  - SER_ENA <= 0, so ENA is high for exactly one cycle.
  - Stay until SER_BUSY=1, then go to WAIT_DONE.
- WAIT_DONE:
  - Stay while SER_BUSY=1.
  - On SER_BUSY=0: if WORD_IDX==len-1, pulse DONE[winner] for one cycle, clear GRANT and WORD_IDX, return to IDLE.
  - Otherwise WORD_IDX <= WORD_IDX+1 and go to LOAD.
- Latency: REQ sampled at edge t; GRANT valid after t; SER_ENA high during the cycle after t+1. Minimum 3 cycles per word plus the serializer busy time.
- Arbitration points: the winner is chosen only in IDLE. Requests that arrive mid-frame wait; GRANT never changes mid-frame.
- REQ dropped by the owner mid-frame: ignored; the frame runs to completion and DONE is still pulsed.
- REQ of a just-finished requester still high in the IDLE cycle after DONE: treated as a new request. Requesters deassert REQ on DONE.
- SER_DATA and SER_ADDR hold their last value between words.
- WORD_IDX wraps never: len is at most 2^LEN_W-1, so the last index fits.
- SER_BUSY already high when entering WAIT_ACK (serializer fast-ack): accepted on that cycle.

Optional Feature:
- Macro SPI_ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration. A last-winner pointer updates at each grant; search starts at last+1 modulo N_REQ. The pointer resets to N_REQ-1, so index 0 has first priority after reset.
- Undefined: fixed priority, lowest index wins. No pointer register.

Test Plan:
- Single frame: REQ=3'b001, LEN0=6, WORD_IN0 driven as {55AA,0082,0001,1000,0000,0000}[WORD_IDX], ADDR_IN0=1, serializer model with busy=17 cycles -> exactly 6 ENA pulses, SER_DATA sequence matches, SER_ADDR=1, then DONE=3'b001 for one cycle and GRANT=0.
- Contention: REQ=3'b110 asserted together, LEN1=2, LEN2=3 -> requester 1 is served fully (2 words) before requester 2 (3 words). GRANT stays 3'b010 throughout the first frame.
- Round-robin (macro defined): REQ held at 3'b111, each LEN=1 -> grant order 0,1,2,0,1. Without the macro, the order is 0,0,0…
- Zero length: REQ=3'b100, LEN2=0 -> no SER_ENA, DONE=3'b100 pulses two cycles after REQ, back to IDLE.
- Reset mid-frame: assert RST=0 in WAIT_DONE during word 2 of 6 -> all outputs 0 immediately. After release with REQ still high, the frame restarts at WORD_IDX=0.
- Handshake: SER_BUSY held low for 10 cycles after ENA -> block remains in WAIT_ACK with no second ENA. BUSY then high 5 cycles and low -> next word's ENA follows 2 cycles later.
